// File: rtl/axi_mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_port_arbiter_if
// Description : Bus bundle between the AXI slave's write/read paths, the
//               memory-port arbiter and the single-port word memory.
//               slave  = arbiter view, master = requester/memory view.
// Revision    : 1.0  initial release
// ============================================================================
interface axi_mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 10
);
    // write requester
    logic                  wr_req;
    logic [MEM_AW-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
    logic                  wr_gnt;
    // read requester
    logic                  rd_req;
    logic [MEM_AW-1:0]     rd_addr;
    logic                  rd_last;
    logic                  rd_gnt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    // memory side
    logic                  mem_en;
    logic                  mem_we;
    logic [MEM_AW-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  wr_req, wr_addr, wr_data, wr_last,
        input  rd_req, rd_addr, rd_last,
        input  mem_rdata,
        output wr_gnt, rd_gnt, rd_data, rd_valid,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output wr_req, wr_addr, wr_data, wr_last,
        output rd_req, rd_addr, rd_last,
        output mem_rdata,
        input  wr_gnt, rd_gnt, rd_data, rd_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/axi_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_port_arbiter
// Description : Shares one single-port word memory between the AXI slave's
//               write and read paths. Whole bursts are granted round-robin,
//               an idle owner is released after HOLD_TIMEOUT cycles, all
//               memory-side outputs are registered and read data returns
//               with a fixed latency of 3 cycles from beat acceptance.
//               Optional macro ARB_WR_PRIORITY_EN: fixed write priority.
// Revision    : 1.0  initial release
// ============================================================================
module axi_mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 1024,
    parameter int HOLD_TIMEOUT = 16
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    axi_mem_port_arbiter_if.slave  bus
);
    localparam int MEM_AW = $clog2(MEMORY_DEPTH);
    localparam int CNT_W  = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    // count value seen on the last idle cycle before a forced release
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'((HOLD_TIMEOUT > 0) ? (HOLD_TIMEOUT - 1) : 0);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WR_OWN = 2'd1;
    localparam logic [1:0] ST_RD_OWN = 2'd2;

    logic [1:0]            state_q,     state_d;
    logic                  last_rd_q,   last_rd_d;   // 1: read path owned last
    logic [CNT_W-1:0]      idle_cnt_q,  idle_cnt_d;
    logic                  mem_en_q,    mem_en_d;
    logic                  mem_we_q,    mem_we_d;
    logic [MEM_AW-1:0]     mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  rd_pend_q,   rd_pend_d;   // read beat whose data arrives this cycle
    logic                  rd_valid_q,  rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;

    logic w_wr_own;
    logic w_rd_own;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_owner_idle;
    logic w_timeout;
    logic w_release;
    logic w_wr_wins_tie;

    // Beat acceptance, owner-idle detection and burst release
    always_comb begin
        w_wr_own     = (state_q == ST_WR_OWN);
        w_rd_own     = (state_q == ST_RD_OWN);
        w_wr_acc     = w_wr_own & bus.wr_req;
        w_rd_acc     = w_rd_own & bus.rd_req;
        w_owner_idle = (w_wr_own & ~bus.wr_req) | (w_rd_own & ~bus.rd_req);
        w_timeout    = (HOLD_TIMEOUT != 0) && w_owner_idle && (idle_cnt_q == TO_LIM);
        w_release    = (w_wr_acc & bus.wr_last) | (w_rd_acc & bus.rd_last) | w_timeout;
`ifdef ARB_WR_PRIORITY_EN
        w_wr_wins_tie = 1'b1;
`else
        w_wr_wins_tie = last_rd_q;
`endif
    end

    // Ownership FSM with round-robin tie break and idle-hold counter
    always_comb begin
        state_d    = state_q;
        last_rd_d  = last_rd_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (bus.wr_req && bus.rd_req) begin
                    state_d = w_wr_wins_tie ? ST_WR_OWN : ST_RD_OWN;
                end else if (bus.wr_req) begin
                    state_d = ST_WR_OWN;
                end else if (bus.rd_req) begin
                    state_d = ST_RD_OWN;
                end
            end
            ST_WR_OWN: begin
                if (w_release) begin
                    last_rd_d  = 1'b0;
                    idle_cnt_d = '0;
`ifdef ARB_WR_PRIORITY_EN
                    // write keeps the port while it keeps requesting
                    state_d = bus.wr_req ? ST_WR_OWN : (bus.rd_req ? ST_RD_OWN : ST_IDLE);
`else
                    state_d = bus.rd_req ? ST_RD_OWN : ST_IDLE;
`endif
                end else if (w_wr_acc) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            ST_RD_OWN: begin
                if (w_release) begin
                    last_rd_d  = 1'b1;
                    idle_cnt_d = '0;
                    state_d    = bus.wr_req ? ST_WR_OWN : ST_IDLE;
                end else if (w_rd_acc) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                idle_cnt_d = '0;
            end
        endcase
    end

    // Memory command registers and the read-return pipeline
    always_comb begin
        mem_en_d    = w_wr_acc | w_rd_acc;
        mem_we_d    = w_wr_acc;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (w_wr_acc) begin
            mem_addr_d  = bus.wr_addr;
            mem_wdata_d = bus.wr_data;
        end else if (w_rd_acc) begin
            mem_addr_d  = bus.rd_addr;
        end
        // a read command issued last cycle has its data on mem_rdata now
        rd_pend_d  = mem_en_q & ~mem_we_q;
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_pend_q ? bus.mem_rdata : rd_data_q;
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            last_rd_q   <= 1'b1;
            idle_cnt_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_rd_q   <= last_rd_d;
            idle_cnt_q  <= idle_cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_pend_q   <= rd_pend_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign bus.wr_gnt    = (state_q == ST_WR_OWN);
    assign bus.rd_gnt    = (state_q == ST_RD_OWN);
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_mem_port_arbiter
// Description : Scoreboard bench for axi_mem_port_arbiter. A transaction
//               level model predicts grants, memory commands and read
//               returns; a monitor compares them against the DUT each cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axi_mem_port_arbiter;
    localparam int DW = 32;
    localparam int DEPTH = 1024;
    localparam int AW = 10;
    localparam int HOLD_TIMEOUT = 16;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    axi_mem_port_arbiter_if #(.DATA_WIDTH(DW), .MEM_AW(AW)) bus ();

    axi_mem_port_arbiter #(
        .DATA_WIDTH  (DW),
        .MEMORY_DEPTH(DEPTH),
        .HOLD_TIMEOUT(HOLD_TIMEOUT)
    ) dut (
        .ACLK   (ACLK),
        .ARESETn(ARESETn),
        .bus    (bus)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [31:0]   due;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [31:0]   due;
    } ret_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    beat_t mq[$];
    ret_t  rq[$];

    function automatic logic [DW-1:0] init_word(int i);
        return (i * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge ACLK) cyc <= cyc + 1;

    // ------------------------------------------------------------------ memory
    logic [DW-1:0] mem [DEPTH];
    logic mem_init = 1'b0;
    always @(posedge ACLK) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    // --------------------------------------------------------- reference model
    logic [DW-1:0] model_mem [DEPTH];
    bit model_init = 1'b0;
    int owner = 0;            // 0 none, 1 write, 2 read
    bit last_wr = 1'b0;       // previous owner was the write path
    int idle = 0;
    logic [DW-1:0] hold_wdata = '0;
    logic [DW-1:0] last_rdata = '0;
    bit wr_acc_f = 1'b0;
    bit rd_acc_f = 1'b0;

    always @(negedge ACLK) begin : model
        beat_t b;
        ret_t  r;
        bit    cur_req, cur_last, rel;
        if (!model_init) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);
            model_init = 1'b1;
        end
        if (!ARESETn) begin
            mq.delete();
            rq.delete();
            owner = 0; last_wr = 1'b0; idle = 0;
            hold_wdata = '0; last_rdata = '0;
            wr_acc_f = 1'b0; rd_acc_f = 1'b0;
            chk("rst_gnt", {bus.wr_gnt, bus.rd_gnt}, 0);
            chk("rst_mem_en", {bus.mem_en, bus.mem_we}, 0);
            chk("rst_rd_valid", bus.rd_valid, 0);
        end else begin
            chk("wr_gnt", bus.wr_gnt, owner == 1);
            chk("rd_gnt", bus.rd_gnt, owner == 2);
            // memory command monitor
            if (mq.size() > 0 && mq[0].due == cyc) begin
                b = mq.pop_front();
                chk("mem_en", bus.mem_en, 1);
                chk("mem_we", bus.mem_we, b.we);
                chk("mem_addr", bus.mem_addr, b.addr);
                chk("mem_wdata", bus.mem_wdata, b.data);
            end else begin
                chk("mem_en_idle", {bus.mem_en, bus.mem_we}, 0);
            end
            // read return monitor
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                chk("rd_valid", bus.rd_valid, 1);
                chk("rd_data", bus.rd_data, r.data);
                last_rdata = r.data;
            end else begin
                chk("rd_valid_idle", bus.rd_valid, 0);
                chk("rd_data_hold", bus.rd_data, last_rdata);
            end
            // beats accepted this cycle
            wr_acc_f = (owner == 1) && bus.wr_req;
            rd_acc_f = (owner == 2) && bus.rd_req;
            if (wr_acc_f) begin
                mq.push_back('{we: 1'b1, addr: bus.wr_addr, data: bus.wr_data, due: cyc + 1});
                model_mem[bus.wr_addr] = bus.wr_data;
                hold_wdata = bus.wr_data;
            end
            if (rd_acc_f) begin
                mq.push_back('{we: 1'b0, addr: bus.rd_addr, data: hold_wdata, due: cyc + 1});
                rq.push_back('{data: model_mem[bus.rd_addr], due: cyc + 3});
            end
            // ownership for next cycle
            if (owner == 0) begin
`ifdef ARB_WR_PRIORITY_EN
                if (bus.wr_req) owner = 1;
                else if (bus.rd_req) owner = 2;
`else
                if (bus.wr_req && bus.rd_req) owner = last_wr ? 2 : 1;
                else if (bus.wr_req) owner = 1;
                else if (bus.rd_req) owner = 2;
`endif
            end else begin
                cur_req  = (owner == 1) ? bus.wr_req  : bus.rd_req;
                cur_last = (owner == 1) ? bus.wr_last : bus.rd_last;
                if (cur_req) begin
                    idle = 0;
                    rel = cur_last;
                end else begin
                    idle++;
                    rel = (HOLD_TIMEOUT > 0) && (idle == HOLD_TIMEOUT);
                end
                if (rel) begin
                    last_wr = (owner == 1);
                    idle = 0;
`ifdef ARB_WR_PRIORITY_EN
                    if (bus.wr_req) owner = 1;
                    else if (last_wr && bus.rd_req) owner = 2;
                    else owner = 0;
`else
                    if (last_wr) owner = bus.rd_req ? 2 : 0;
                    else owner = bus.wr_req ? 1 : 0;
`endif
                end
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    int wr_left = 0, wr_bl = 1, wr_bi = 0, wr_pct = 100;
    int rd_left = 0, rd_bl = 1, rd_bi = 0, rd_pct = 100;
    logic [AW-1:0] wr_a = '0, rd_a = '0;
    logic [DW-1:0] wr_d = '0;
    bit rnd_mode = 1'b0;

    function automatic int pick_pct();
        case ($urandom_range(0, 4))
            0, 1:    return 100;
            2:       return 80;
            3:       return 40;
            default: return 10;
        endcase
    endfunction

    task automatic step();
        @(posedge ACLK);
        #1;
        if (wr_acc_f) begin
            wr_left--; wr_a++; wr_d = $urandom; wr_bi = (wr_bi + 1) % wr_bl;
        end
        if (rd_acc_f) begin
            rd_left--; rd_a++; rd_bi = (rd_bi + 1) % rd_bl;
        end
        if (rnd_mode) begin
            if (wr_left == 0 && $urandom_range(0, 3) == 0) begin
                wr_bl = $urandom_range(1, 4); wr_left = wr_bl; wr_bi = 0;
                wr_a = AW'($urandom_range(0, 63)); wr_d = $urandom; wr_pct = pick_pct();
            end
            if (rd_left == 0 && $urandom_range(0, 3) == 0) begin
                rd_bl = $urandom_range(1, 4); rd_left = rd_bl; rd_bi = 0;
                rd_a = AW'($urandom_range(0, 63)); rd_pct = pick_pct();
            end
            if ($urandom_range(0, 49) == 0) wr_pct = pick_pct();
            if ($urandom_range(0, 49) == 0) rd_pct = pick_pct();
        end
        bus.wr_req  = (wr_left > 0) && ($urandom_range(0, 99) < wr_pct);
        bus.wr_addr = wr_a;
        bus.wr_data = wr_d;
        bus.wr_last = (wr_bi == wr_bl - 1);
        bus.rd_req  = (rd_left > 0) && ($urandom_range(0, 99) < rd_pct);
        bus.rd_addr = rd_a;
        bus.rd_last = (rd_bi == rd_bl - 1);
    endtask

    task automatic run_until_done(string name);
        bit done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (wr_left == 0 && rd_left == 0) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk(name, done, 1);
        repeat (5) step();
    endtask

    task automatic start_wr(logic [AW-1:0] a, int n, int bl, logic [DW-1:0] d);
        wr_a = a; wr_left = n; wr_bl = bl; wr_bi = 0; wr_d = d; wr_pct = 100;
    endtask

    task automatic start_rd(logic [AW-1:0] a, int n, int bl);
        rd_a = a; rd_left = n; rd_bl = bl; rd_bi = 0; rd_pct = 100;
    endtask

    initial begin
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_last = 1'b0;
        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.rd_last = 1'b0;
        #32 ARESETn = 1'b1;
        repeat (2) step();

        // single write beat with last
        start_wr(AW'(10'h010), 1, 1, 32'hDEADBEEF);
        run_until_done("single_wr_budget");

        // 4-beat write then 4-beat read of the same words
        start_wr(AW'(10'h020), 4, 4, 32'h11110000);
        run_until_done("burst_wr_budget");
        start_rd(AW'(10'h020), 4, 4);
        run_until_done("burst_rd_budget");

        // both requesters with 2-beat bursts: direct alternating handoff
        start_wr(AW'(10'h040), 8, 2, 32'hA5A50000);
        start_rd(AW'(10'h020), 8, 2);
        run_until_done("alternate_budget");

        // read owner goes idle while write waits: forced release
        start_rd(AW'(10'h030), 4, 4);
        for (int i = 0; i < 50 && rd_left == 4; i++) step();
        chk("to_rd_first_beat", rd_left, 3);
        rd_pct = 0;
        start_wr(AW'(10'h050), 2, 2, 32'hC0DE0000);
        repeat (25) step();
        chk("to_wr_served", wr_left, 0);
        rd_left = 0; rd_pct = 100;
        repeat (3) step();

        // reset one cycle after a read accept drops the in-flight read
        start_rd(AW'(10'h020), 1, 1);
        for (int i = 0; i < 50 && rd_left == 1; i++) step();
        chk("rst_rd_accepted", rd_left, 0);
        ARESETn = 1'b0;
        #1;
        chk("rst_now_gnt", {bus.wr_gnt, bus.rd_gnt}, 0);
        chk("rst_now_mem", {bus.mem_en, bus.mem_we, bus.mem_addr}, 0);
        chk("rst_now_wdata", bus.mem_wdata, 0);
        chk("rst_now_rd", {bus.rd_valid, bus.rd_data}, 0);
        @(negedge ACLK);
        @(negedge ACLK);
        #2 ARESETn = 1'b1;
        start_wr(AW'(10'h060), 1, 1, 32'h600D600D);
        start_rd(AW'(10'h061), 1, 1);
        run_until_done("post_rst_budget");

        // randomized traffic
        rnd_mode = 1'b1;
        repeat (3000) step();
        rnd_mode = 1'b0;
        wr_pct = 100; rd_pct = 100;
        run_until_done("drain_budget");
        repeat (10) step();
        chk("sb_mem_empty", mq.size(), 0);
        chk("sb_rd_empty", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axi_mem_port_arbiter.md
Name: axi_mem_port_arbiter

Overview:
- Shares the single-port word memory between the AXI4 slave's write path and read path.
- Without this block, both channel FSMs drive mem_en independently.
- Grants whole bursts to one requester at a time, round-robin between write and read, with an idle-hold timeout.
- Registers all memory-side outputs and returns read data to the read requester with fixed latency.

Parameters:
DATA_WIDTH  32  memory data width
MEMORY_DEPTH  1024  memory words; MEM_AW = $clog2(MEMORY_DEPTH)
HOLD_TIMEOUT  16  consecutive owner-idle cycles before forced release; 0 disables the timeout

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
wr_req  in  1  write beat request
wr_addr  in  MEM_AW  write word address
wr_data  in  DATA_WIDTH  write data
wr_last  in  1  final beat of write burst
wr_gnt  out  1  write path owns port
rd_req  in  1  read beat request
rd_addr  in  MEM_AW  read word address
rd_last  in  1  final beat of read burst
rd_gnt  out  1  read path owns port
rd_data  out  DATA_WIDTH  returned read data
rd_valid  out  1  rd_data valid, one-cycle pulse per read beat
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  MEM_AW  memory word address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read mem_en

Behaviour:
- Reset (async, ARESETn low):
  - state=IDLE; all outputs 0.
  - last_owner=RD, so write wins the first tie.
  - idle counter 0; read-return pipeline flushed.
  - In-flight reads are dropped and never produce rd_valid.
- States: IDLE, WR_OWN, RD_OWN.
- Grants are registered: wr_gnt = (state==WR_OWN), rd_gnt = (state==RD_OWN).
- IDLE arbitration:
  - wr_req only -> WR_OWN; rd_req only -> RD_OWN.
  - Both requesting -> requester != last_owner.
  - Neither requesting -> stay IDLE.
  - IDLE grants nothing, so the first burst after IDLE costs one bubble cycle.
- Beat acceptance: cycle N with X_req && X_gnt.
  - Cycle N+1: mem_en=1, mem_addr=X_addr.
  - Write: mem_we=1, mem_wdata=wr_data.
  - Read: mem_we=0; mem_wdata holds its previous value.
  - mem_en/mem_we default to 0 in every cycle with no acceptance.
- Back-to-back beats: one per cycle while owner keeps req high; no bubbles within a burst.
- Burst end: accepted beat with X_last=1 sets last_owner=X and hands off.
  - Other requester has req high -> go directly to its OWN state (gnt swaps with no IDLE cycle).
  - Otherwise -> IDLE.
- Owner idle (gnt high, req low): idle counter increments each cycle and clears on any accepted beat.
  - Reaching HOLD_TIMEOUT forces release exactly as a last beat.
  - The requester must re-request later; the burst is treated as aborted.
- Read return:
  - mem_rdata is sampled in cycle N+2 into rd_data.
  - rd_valid=1 in cycle N+3 for one cycle; latency 3 from acceptance, fully pipelined.
  - rd_data holds its value when rd_valid=0.
  - The pipeline keeps draining after ownership changes.
- req on a non-owned side is ignored; no beat is taken.
- Address and data are passed through unmodified; range checking stays in the AXI slave.

Optional Feature:
- Macro: ARB_WR_PRIORITY_EN.
- Defined:
  - Fixed priority: write always wins IDLE ties and end-of-burst handoff.
  - last_owner is ignored; the read path can only win when wr_req=0.
  - HOLD_TIMEOUT still applies.
- Undefined: round-robin as above.

Test Plan:
- Reset, then wr_req=1 with addr 0x010, data 0xDEADBEEF, wr_last=1 -> wr_gnt high cycle 2; mem_en=mem_we=1, mem_addr=0x010, mem_wdata=0xDEADBEEF one cycle after acceptance; state returns to IDLE.
- Write a 4-beat burst at 0x020..0x023, then a 4-beat read of the same addresses -> rd_valid pulses four consecutive cycles, 3 cycles after each accept, with matching data.
- Both requesters hold req with 2-beat bursts -> grants alternate WR, RD, WR, RD with direct handoff and no IDLE cycles. With ARB_WR_PRIORITY_EN defined, WR holds the port while wr_req stays high.
- Owner is read, rd_req dropped mid-burst, wr_req=1 -> after 16 idle cycles rd_gnt falls and wr_gnt rises next cycle. With HOLD_TIMEOUT=0, rd_gnt is held indefinitely.
- ARESETn pulsed low one cycle after a read accept -> no rd_valid; all outputs 0 immediately; write wins the first grant after release.
- rd_req asserted while wr owns the port -> no mem_en for read until handoff; no spurious beat.
